pc_sequencer: RTL and testbench

- Program-counter sequencer for the core fetch stage: owns the PC register, selects next PC (increment, table branch or halt) and holds the 16-entry branch-target table that the branch field indexes.
- The table can be rewritten at runtime through a config port while the core is idle or halted.
- Sits between the decoder (branch/halt requests) and instruction ROM (pc address).

---
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Decoder/ROM-side bus of the PC sequencer: requests, table config port and fetch outputs.
// PC_SEQ_RET_EN adds the link_en/ret_en return-address requests.
interface pc_sequencer_if #(
  parameter int unsigned D = 10,
  parameter int unsigned A = 4
);
  logic          start;
  logic          stall;
  logic          branch_en;
  logic [A-1:0]  branch_idx;
  logic          halt_req;
  logic          cfg_we;
  logic [A-1:0]  cfg_addr;
  logic [D-1:0]  cfg_data;
`ifdef PC_SEQ_RET_EN
  logic          link_en;
  logic          ret_en;
`endif
  logic [D-1:0]  pc;
  logic          running;
  logic          done;
  logic          cfg_err;
  logic [15:0]   fetch_count;

  modport master (
`ifdef PC_SEQ_RET_EN
    output link_en, ret_en,
`endif
    output start, stall, branch_en, branch_idx, halt_req, cfg_we, cfg_addr, cfg_data,
    input  pc, running, done, cfg_err, fetch_count
  );

  modport slave (
`ifdef PC_SEQ_RET_EN
    input  link_en, ret_en,
`endif
    input  start, stall, branch_en, branch_idx, halt_req, cfg_we, cfg_addr, cfg_data,
    output pc, running, done, cfg_err, fetch_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with a runtime-writable 2^A-entry branch-target table.
// Optional return-address register (link_en/ret_en) enabled by defining PC_SEQ_RET_EN.
module pc_sequencer #(
  parameter int unsigned D        = 10,
  parameter int unsigned A        = 4,
  parameter int unsigned START_PC = 1
) (
  input logic              clk,
  input logic              reset,
  pc_sequencer_if.slave    bus
);

  localparam int unsigned N  = 2 ** A;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t         state_q;
  logic [D-1:0]   pc_q;
  logic [D-1:0]   tgt_q [N];
  logic           running_q;
  logic           done_q;
  logic           cfg_err_q;
  logic [CW-1:0]  cnt_q;
`ifdef PC_SEQ_RET_EN
  logic [D-1:0]   ret_pc_q;
`endif

  logic [D-1:0]   pc_inc_d;
  logic [D-1:0]   br_tgt_d;
  logic           cfg_ok_d;

  function automatic logic [D-1:0] default_tgt(input int unsigned i);
    case (i)
      1:       default_tgt = D'(11);
      2:       default_tgt = D'(80);
      3:       default_tgt = D'(68);
      4:       default_tgt = D'(116);
      5:       default_tgt = D'(53);
      6:       default_tgt = D'(56);
      7:       default_tgt = D'(59);
      8:       default_tgt = D'(77);
      9:       default_tgt = D'(20);
      10:      default_tgt = D'(1);
      11:      default_tgt = D'(44);
      default: default_tgt = '0;
    endcase
  endfunction

  assign pc_inc_d = pc_q + D'(1);
  assign br_tgt_d = tgt_q[bus.branch_idx];
  assign cfg_ok_d = bus.cfg_we && (state_q != RUN);

  // Branch-target table; rewrites only land while the core is not running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) tgt_q[i] <= default_tgt(i);
    end else if (cfg_ok_d) begin
      tgt_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
`ifdef PC_SEQ_RET_EN
      ret_pc_q  <= '0;
`endif
    end else begin
      cfg_err_q <= bus.cfg_we && (state_q == RUN);
      case (state_q)
        IDLE, HALT: begin
          if (bus.start) begin
            state_q   <= RUN;
            pc_q      <= D'(START_PC);
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
`ifdef PC_SEQ_RET_EN
            ret_pc_q  <= '0;
`endif
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + CW'(1);
            // Halt outranks every PC-changing request; pc stays on the end instruction
            if (bus.halt_req) begin
              state_q   <= HALT;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
`ifdef PC_SEQ_RET_EN
            else if (bus.ret_en) begin
              pc_q <= ret_pc_q;
            end
`endif
            else if (bus.branch_en) begin
              pc_q <= br_tgt_d;
`ifdef PC_SEQ_RET_EN
              if (bus.link_en) ret_pc_q <= pc_inc_d;
`endif
            end else begin
              pc_q <= pc_inc_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector-table bench for pc_sequencer: expected outputs queued on drive, checked one edge later.
module tb_pc_sequencer;

  localparam int unsigned D = 10;
  localparam int unsigned A = 4;

  typedef struct {
    logic         start, stall, br;
    logic [A-1:0] bi;
    logic         halt, we;
    logic [A-1:0] wa;
    logic [D-1:0] wd;
    logic [D-1:0] pc;
    logic         run, done, err;
    logic [15:0]  cnt;
  } vec_t;

  typedef struct {
    logic [D-1:0] pc;
    logic         run, done, err;
    logic [15:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  pc_sequencer_if #(.D(D), .A(A)) bus ();

  pc_sequencer #(.D(D), .A(A), .START_PC(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, st, b, input int bi, input logic h, we,
                              input int wa, wd, pc, input logic run, done, err, input int cnt);
    vec_t v;
    v.start = s;  v.stall = st; v.br = b;   v.bi = A'(bi);
    v.halt  = h;  v.we = we;    v.wa = A'(wa); v.wd = D'(wd);
    v.pc = D'(pc); v.run = run; v.done = done; v.err = err; v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic push_exp(input int pc, input logic run, done, err, input int cnt);
    exp_t e;
    e.pc = D'(pc); e.run = run; e.done = done; e.err = err; e.cnt = 16'(cnt);
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    if (bus.pc !== e.pc || bus.running !== e.run || bus.done !== e.done ||
        bus.cfg_err !== e.err || bus.fetch_count !== e.cnt) begin
      n_err++;
      $display("FAIL %s: got pc=%0d run=%0b done=%0b err=%0b cnt=%0d, want pc=%0d run=%0b done=%0b err=%0b cnt=%0d",
               name, bus.pc, bus.running, bus.done, bus.cfg_err, bus.fetch_count,
               e.pc, e.run, e.done, e.err, e.cnt);
    end
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_idx = '0;
    bus.halt_req = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
`ifdef PC_SEQ_RET_EN
    bus.link_en = 1'b0; bus.ret_en = 1'b0;
`endif
  endtask

  task automatic apply(input vec_t v, input string name);
    bus.start = v.start; bus.stall = v.stall; bus.branch_en = v.br; bus.branch_idx = v.bi;
    bus.halt_req = v.halt; bus.cfg_we = v.we; bus.cfg_addr = v.wa; bus.cfg_data = v.wd;
    push_exp(int'(v.pc), v.run, v.done, v.err, int'(v.cnt));
    @(posedge clk);
    #1;
    pop_check(name);
  endtask

  initial begin
    int k;
    drive_idle();

    //        s  st b  bi h  we wa  wd    pc   run done err cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,     0, 0, 0, 0,  0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,     1, 1, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,     2, 1, 0, 0,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,     3, 1, 0, 0,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,     4, 1, 0, 0,  3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,     5, 1, 0, 0,  4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,     6, 1, 0, 0,  5));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0,  0,    80, 1, 0, 0,  6));
    vecs.push_back(mk(0, 0, 1, 11,0, 0, 0,  0,    44, 1, 0, 0,  7));
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0,  0,    44, 1, 0, 0,  7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,    45, 1, 0, 0,  8));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,    46, 1, 0, 0,  9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 13, 7,    47, 1, 0, 1, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,    48, 1, 0, 0, 11));
    vecs.push_back(mk(0, 0, 1, 2, 1, 0, 0,  0,    48, 0, 1, 0, 12));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,    48, 0, 1, 0, 12));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 14, 1023, 48, 0, 1, 0, 12));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 13, 500,   1, 1, 0, 0,  0));
    vecs.push_back(mk(0, 0, 1, 13,0, 0, 0,  0,   500, 1, 0, 0,  1));
    vecs.push_back(mk(0, 0, 1, 14,0, 0, 0,  0,  1023, 1, 0, 0,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,     0, 1, 0, 0,  3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0,     0, 1, 0, 0,  3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0,     0, 0, 1, 0,  4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,     1, 1, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 13, 9,     2, 1, 0, 1,  1));
    vecs.push_back(mk(0, 0, 1, 13,0, 0, 0,  0,   500, 1, 0, 0,  2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0,   500, 0, 1, 0,  3));

    // Reset state, observed while reset is still asserted
    repeat (2) @(posedge clk);
    #1;
    push_exp(0, 0, 0, 0, 0);
    pop_check("reset_state");
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // fetch_count saturation across many PC wraps
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "sat_start");
    drive_idle();
    k = 65535;
    repeat (k) @(posedge clk);
    #1;
    push_exp((1 + k) % (1 << D), 1, 0, 0, 16'hFFFF);
    pop_check("sat_reach");
    @(posedge clk);
    #1;
    push_exp((2 + k) % (1 << D), 1, 0, 0, 16'hFFFF);
    pop_check("sat_hold");

    // Async reset mid-RUN: pc must clear before the next clock edge
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    push_exp(0, 0, 0, 0, 0);
    pop_check("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "post_rst_start");
    apply(mk(0, 0, 1, 13, 0, 0, 0, 0, 0, 1, 0, 0, 1), "post_rst_entry13");
    apply(mk(0, 0, 1, 2, 0, 0, 0, 0, 80, 1, 0, 0, 2), "post_rst_entry2");

`ifdef PC_SEQ_RET_EN
    apply(mk(0, 0, 1, 9, 0, 0, 0, 0, 20, 1, 0, 0, 3), "ret_to20");
    bus.link_en = 1'b1;
    apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 11, 1, 0, 0, 4), "ret_link");
    bus.link_en = 1'b0;
    bus.ret_en = 1'b1;
    apply(mk(0, 0, 1, 2, 0, 0, 0, 0, 21, 1, 0, 0, 5), "ret_return");
    bus.ret_en = 1'b0;
`endif

    drive_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
